// File: rtl/axis_reg_buffer.sv
// rtl/axis_reg_buffer.sv - two-entry AXI-Stream register slice (skid buffer), all outputs from flops
module axis_reg_buffer #(
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              tvalid_i,
    output logic              tready_o,
    input  logic [DATA_W-1:0] tdata_i,
    input  logic              tready_i,
    output logic              tvalid_o,
    output logic [DATA_W-1:0] tdata_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              tready_q, tready_d;
    logic              tvalid_q, tvalid_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = tvalid_i & tready_q;
    assign out_fire = tvalid_q & tready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = tdata_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = tdata_i;
                end else if (in_fire) begin
                    skid_d  = tdata_i;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // tready_o is low here, so only the drain side can move
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs are flops carrying the next state's decode, so no
    // combinational path runs from tready_i to tready_o or tvalid_i to tvalid_o.
    always_comb begin
        tready_d = (state_d != ST_FULL);
        tvalid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= ST_EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign tready_o = tready_q;
    assign tvalid_o = tvalid_q;
    assign tdata_o  = main_q;

endmodule

// File: tb/tb_axis_reg_buffer.sv
// tb/tb_axis_reg_buffer.sv - self-checking bench for axis_reg_buffer
module tb_axis_reg_buffer;

    logic       clk_i = 1'b0;
    logic       arstn_i;
    logic       tvalid_i;
    logic       tready_o;
    logic [3:0] tdata_i;
    logic       tready_i;
    logic       tvalid_o;
    logic [3:0] tdata_o;

    int checks   = 0;
    int failures = 0;

    axis_reg_buffer #(.DATA_W(4)) dut (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .tvalid_i (tvalid_i),
        .tready_o (tready_o),
        .tdata_i  (tdata_i),
        .tready_i (tready_i),
        .tvalid_o (tvalid_o),
        .tdata_o  (tdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       tv;
        logic [3:0] td;
        logic       tr;
        logic       exp_v;
        logic [3:0] exp_d;
        logic       exp_r;
    } vec_t;

    vec_t vecs[20];

    // reference model: FIFO of at most two beats
    logic [3:0] mq[$];
    logic [3:0] m_last;
    logic       m_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_vec(input int i, input logic tv, input logic [3:0] td, input logic tr,
                           input logic ev, input logic [3:0] ed, input logic er);
        vecs[i].tv = tv; vecs[i].td = td; vecs[i].tr = tr;
        vecs[i].exp_v = ev; vecs[i].exp_d = ed; vecs[i].exp_r = er;
    endtask

    initial begin
        arstn_i  = 1'b0;
        tvalid_i = 1'b0;
        tdata_i  = 4'h0;
        tready_i = 1'b0;

        // fill/stall, drain, stream, back-pressure (source holds B until accepted)
        set_vec( 0, 1, 4'h1, 0, 1, 4'h1, 1);
        set_vec( 1, 1, 4'h8, 0, 1, 4'h1, 0);
        set_vec( 2, 1, 4'h2, 0, 1, 4'h1, 0);
        set_vec( 3, 0, 4'h2, 1, 1, 4'h8, 1);
        set_vec( 4, 0, 4'h2, 1, 0, 4'h8, 1);
        set_vec( 5, 1, 4'h3, 1, 1, 4'h3, 1);
        set_vec( 6, 1, 4'h9, 1, 1, 4'h9, 1);
        set_vec( 7, 1, 4'h3, 1, 1, 4'h3, 1);
        set_vec( 8, 1, 4'hE, 1, 1, 4'hE, 1);
        set_vec( 9, 1, 4'h8, 1, 1, 4'h8, 1);
        set_vec(10, 0, 4'h0, 1, 0, 4'h8, 1);
        set_vec(11, 1, 4'h3, 1, 1, 4'h3, 1);
        set_vec(12, 1, 4'h9, 0, 1, 4'h3, 0);
        set_vec(13, 1, 4'hB, 0, 1, 4'h3, 0);
        set_vec(14, 1, 4'hB, 0, 1, 4'h3, 0);
        set_vec(15, 1, 4'hB, 1, 1, 4'h9, 1);
        set_vec(16, 1, 4'hB, 1, 1, 4'hB, 1);
        set_vec(17, 1, 4'hD, 1, 1, 4'hD, 1);
        set_vec(18, 1, 4'h7, 1, 1, 4'h7, 1);
        set_vec(19, 0, 4'h0, 1, 0, 4'h7, 1);

        // reset held with random inputs
        for (int i = 0; i < 40; i++) begin
            tvalid_i = 1'($urandom);
            tdata_i  = 4'($urandom);
            tready_i = 1'($urandom);
            cycle();
            if (i % 8 == 0) begin
                check("rst_tvalid", tvalid_o, 0);
                check("rst_tdata",  tdata_o,  0);
                check("rst_tready", tready_o, 0);
            end
        end
        tvalid_i = 1'b0;
        tready_i = 1'b0;
        tdata_i  = 4'h0;
        arstn_i  = 1'b1;
        #1;
        check("rel_tready_before_edge", tready_o, 0);
        cycle();
        check("rel_tready_after_edge", tready_o, 1);
        check("rel_tvalid", tvalid_o, 0);
        check("rel_tdata",  tdata_o,  0);

        for (int i = 0; i < 20; i++) begin
            tvalid_i = vecs[i].tv;
            tdata_i  = vecs[i].td;
            tready_i = vecs[i].tr;
            cycle();
            check($sformatf("vec%0d_tvalid", i), tvalid_o, vecs[i].exp_v);
            check($sformatf("vec%0d_tdata",  i), tdata_o,  vecs[i].exp_d);
            check($sformatf("vec%0d_tready", i), tready_o, vecs[i].exp_r);
        end

        // fill to FULL, then reset asynchronously between edges
        tready_i = 1'b0;
        tvalid_i = 1'b1; tdata_i = 4'h5; cycle();
        tdata_i  = 4'hA; cycle();
        check("full_tready", tready_o, 0);
        check("full_tdata",  tdata_o,  4'h5);
        #2;
        arstn_i = 1'b0;
        #1;
        check("async_tvalid", tvalid_o, 0);
        check("async_tdata",  tdata_o,  0);
        check("async_tready", tready_o, 0);
        tvalid_i = 1'b0;
        tready_i = 1'b1;
        cycle();
        arstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_rst_tvalid", tvalid_o, 0);
            check("post_rst_tready", tready_o, 1);
            check("post_rst_tdata",  tdata_o,  0);
        end

        // randomized traffic against the queue model
        mq.delete();
        m_last = 4'h0;
        m_rdy  = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic in_f, out_f;
            tvalid_i = ($urandom_range(0, 3) != 0);
            tdata_i  = 4'($urandom);
            tready_i = ($urandom_range(0, 2) != 0);
            in_f  = tvalid_i && m_rdy;
            out_f = (mq.size() != 0) && tready_i;
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(tdata_i);
            if (mq.size() != 0) m_last = mq[0];
            m_rdy = (mq.size() < 2);
            cycle();
            check("rnd_tvalid", tvalid_o, (mq.size() != 0));
            check("rnd_tready", tready_o, m_rdy);
            check("rnd_tdata",  tdata_o,  m_last);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
